axi_burst_sram_slave: RTL and testbench

AXI_BURST_SRAM_SLAVE -- requirements
Module: axi_burst_sram_slave

---
 rtl/axi_pkg.sv | 28 ++
 rtl/sram_1r1w_be.sv | 35 +++
 rtl/axi_burst_sram_slave.sv | 211 +++++++++++++++++++++
 tb/tb_axi_burst_sram_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings, widths and FSM state types for the burst SRAM slave.
package axi_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_BURST} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    // WRAP bursts deliberately advance like INCR; reserved encodings hold the address.
    function automatic logic [ADDR_W-1:0] next_beat_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [1:0]        burst,
        input logic [2:0]        size
    );
        if (burst == BURST_INCR || burst == BURST_WRAP) begin
            return addr + (ADDR_W'(1) << size);
        end
        return addr;
    endfunction
endpackage

// File: rtl/sram_1r1w_be.sv
// 64-bit wide storage with one registered read port and one byte-enabled write port.
// A read and write to the same word in one cycle returns the pre-write data.
module sram_1r1w_be
    import axi_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
        if (wr_en_i) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb_i[i]) begin
                    mem_q[wr_idx_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/axi_burst_sram_slave.sv
// AXI burst slave over a single-port-pair SRAM; read and write channels run independently.
// Define AXI_SLAVE_RANGE_CHECK_EN to answer out-of-window beats with SLVERR instead of wrapping.
module axi_burst_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [1:0]  arburst,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    output logic        rlast,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [1:0]  awburst,
    input  logic [7:0]  awlen,
    output logic        awready,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    input  logic        wlast,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 3);
    endfunction

`ifdef AXI_SLAVE_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS) << 3;
    // Offsets below BASE_ADDR wrap to huge values, so one compare covers both ends.
    function automatic logic in_span(input logic [ADDR_W-1:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction
`endif

    rd_state_e         rstate_q, rstate_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, rd_addr_sel;
    logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [2:0]        rsize_q, rsize_d;
    logic              rerr_q, rerr_d, rd_en;
    logic [DATA_W-1:0] sram_rdata;

    wr_state_e         wstate_q, wstate_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0]        wburst_q, wburst_d;
    logic              berr_q, berr_d, wr_en;

    always_comb begin
        rstate_d    = rstate_q;
        raddr_d     = raddr_q;
        rlen_d      = rlen_q;
        rburst_d    = rburst_q;
        rsize_d     = rsize_q;
        rbeat_d     = rbeat_q;
        rerr_d      = rerr_q;
        rd_en       = 1'b0;
        rd_addr_sel = raddr_q;
        arready     = (rstate_q == R_IDLE);
        rvalid      = (rstate_q == R_BURST);
        rlast       = rvalid && (rbeat_q == rlen_q);
        case (rstate_q)
            R_IDLE: begin
                if (arvalid) begin
                    rd_en       = 1'b1;
                    rd_addr_sel = araddr;
                    raddr_d     = araddr;
                    rlen_d      = arlen;
                    rburst_d    = arburst;
                    rsize_d     = arsize;
                    rbeat_d     = 8'd0;
                    rerr_d      = 1'b0;
                    rstate_d    = R_BURST;
                end
            end
            R_BURST: begin
                // The next word is fetched only on acceptance, so rdata holds while stalled.
                if (rready) begin
                    if (rlast) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rd_en       = 1'b1;
                        rd_addr_sel = next_beat_addr(raddr_q, rburst_q, rsize_q);
                        raddr_d     = rd_addr_sel;
                        rbeat_d     = rbeat_q + 8'd1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        if (rd_en) begin
            rerr_d = !in_span(rd_addr_sel);
        end
`endif
    end

    assign rdata = (rvalid && !rerr_q) ? sram_rdata : '0;
    assign rresp = (rvalid && rerr_q) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        wbeat_d  = wbeat_q;
        berr_d   = berr_q;
        wr_en    = 1'b0;
        awready  = (wstate_q == W_IDLE);
        wready   = (wstate_q == W_DATA);
        bvalid   = (wstate_q == W_RESP);
        case (wstate_q)
            W_IDLE: begin
                if (awvalid) begin
                    waddr_d  = awaddr;
                    wlen_d   = awlen;
                    wburst_d = awburst;
                    wbeat_d  = 8'd0;
                    berr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    wr_en = 1'b1;
`ifdef AXI_SLAVE_RANGE_CHECK_EN
                    if (!in_span(waddr_q)) begin
                        wr_en  = 1'b0;
                        berr_d = 1'b1;
                    end
`endif
                    waddr_d = next_beat_addr(waddr_q, wburst_q, 3'd3);
                    wbeat_d = wbeat_q + 8'd1;
                    // Whichever of wlast or the length count comes first closes the burst.
                    if (wlast || wbeat_q == wlen_q) begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign bresp = (bvalid && berr_q) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rsize_q  <= '0;
            rbeat_q  <= '0;
            rerr_q   <= 1'b0;
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wbeat_q  <= '0;
            berr_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rsize_q  <= rsize_d;
            rbeat_q  <= rbeat_d;
            rerr_q   <= rerr_d;
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wbeat_q  <= wbeat_d;
            berr_q   <= berr_d;
        end
    end

    sram_1r1w_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk       (clk),
        .rd_en_i   (rd_en),
        .rd_idx_i  (word_idx(rd_addr_sel)),
        .rd_data_o (sram_rdata),
        .wr_en_i   (wr_en),
        .wr_idx_i  (word_idx(waddr_q)),
        .wr_data_i (wdata),
        .wr_strb_i (wstrb)
    );
endmodule

// File: tb/tb_axi_burst_sram_slave.sv
// Directed bench for axi_burst_sram_slave; range-check expectations follow AXI_SLAVE_RANGE_CHECK_EN.
module tb_axi_burst_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic [1:0]  arburst;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [1:0]  awburst;
    logic [7:0]  awlen;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int tests = 0;
    int fails = 0;

    logic [63:0] rd_data_a [16];
    logic [1:0]  rd_resp_a [16];
    logic        rd_last_a [16];
    int          nbeats;
    logic [63:0] wbuf_data [8];
    logic [7:0]  wbuf_strb [8];
    logic [1:0]  wr_resp;

    axi_burst_sram_slave dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arburst (arburst),
        .arlen   (arlen),
        .arsize  (arsize),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rlast   (rlast),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awburst (awburst),
        .awlen   (awlen),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wlast   (wlast),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input int n,
                             output logic [1:0] resp);
        int cyc;
        @(negedge clk);
        awaddr = addr; awlen = len; awburst = 2'b01; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
        check("aw_accept", {63'd0, awready}, 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = (i == n - 1); wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < 20) begin @(negedge clk); cyc++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        check("b_valid", {63'd0, bvalid}, 64'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
        check("b_done_awready", {63'd0, awready}, 64'd1);
        $display("[TB] write addr=%h len=%0d beats=%0d bresp=%0d", addr, len, n, resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit stall);
        int cyc;
        int phase;
        bit stalled;
        logic [63:0] held;
        nbeats = 0; stalled = 1'b0; held = '0; phase = 0;
        @(negedge clk);
        araddr = addr; arlen = len; arburst = burst; arsize = 3'd3; arvalid = 1'b1; rready = 1'b0;
        cyc = 0;
        while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
        check("ar_accept", {63'd0, arready}, 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("first_rvalid", {63'd0, rvalid}, 64'd1);
        cyc = 0;
        while (rvalid && cyc < 64) begin
            if (stalled) check("stall_hold", rdata, held);
            rready = stall ? ((phase % 4) == 0 || (phase % 4) == 3) : 1'b1;
            phase++;
            if (rready) begin
                if (nbeats < 16) begin
                    rd_data_a[nbeats] = rdata;
                    rd_resp_a[nbeats] = rresp;
                    rd_last_a[nbeats] = rlast;
                end
                nbeats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = rdata;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check("r_burst_bounded", {63'd0, cyc < 64}, 64'd1);
        $display("[TB] read addr=%h len=%0d burst=%0d beats=%0d", addr, len, burst, nbeats);
    endtask

    initial begin
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; arburst = 2'b01; arlen = '0; arsize = 3'd3; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; awburst = 2'b01; awlen = '0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_arready", {63'd0, arready}, 64'd1);
        check("rst_awready", {63'd0, awready}, 64'd1);
        check("rst_rvalid", {63'd0, rvalid}, 64'd0);
        check("rst_rlast", {63'd0, rlast}, 64'd0);
        check("rst_wready", {63'd0, wready}, 64'd0);
        check("rst_bvalid", {63'd0, bvalid}, 64'd0);
        check("rst_rresp", {62'd0, rresp}, 64'd0);
        check("rst_bresp", {62'd0, bresp}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Preload words 0..7
        for (int i = 0; i < 8; i++) begin
            wbuf_data[i] = 64'hA5A5_0000_5A5A_0000 + 64'(i);
            wbuf_strb[i] = 8'hFF;
        end
        axi_write(32'h8000_0000, 8'd7, 8, wr_resp);
        check("preload_bresp", {62'd0, wr_resp}, 64'd0);

        // Two-beat INCR read
        axi_read(32'h8000_0000, 8'd1, 2'b01, 1'b0);
        check("incr_nbeats", 64'(nbeats), 64'd2);
        check("incr_w0", rd_data_a[0], 64'hA5A5_0000_5A5A_0000);
        check("incr_w1", rd_data_a[1], 64'hA5A5_0000_5A5A_0001);
        check("incr_last0", {63'd0, rd_last_a[0]}, 64'd0);
        check("incr_last1", {63'd0, rd_last_a[1]}, 64'd1);
        check("incr_rresp", {62'd0, rd_resp_a[1]}, 64'd0);

        // Byte-strobed write burst
        wbuf_data[0] = 64'h1122_3344_5566_7788; wbuf_strb[0] = 8'hFF;
        wbuf_data[1] = 64'h0000_0000_0000_AAAA; wbuf_strb[1] = 8'h03;
        axi_write(32'h8000_0010, 8'd1, 2, wr_resp);
        check("strb_bresp", {62'd0, wr_resp}, 64'd0);

        // Four-beat read with rready 1,0,0,1 stalls
        axi_read(32'h8000_0000, 8'd3, 2'b01, 1'b1);
        check("stall_nbeats", 64'(nbeats), 64'd4);
        check("stall_w0", rd_data_a[0], 64'hA5A5_0000_5A5A_0000);
        check("stall_w1", rd_data_a[1], 64'hA5A5_0000_5A5A_0001);
        check("stall_w2", rd_data_a[2], 64'h1122_3344_5566_7788);
        check("stall_w3", rd_data_a[3], 64'hA5A5_0000_5A5A_AAAA);
        check("stall_last0", {63'd0, rd_last_a[0]}, 64'd0);
        check("stall_last1", {63'd0, rd_last_a[1]}, 64'd0);
        check("stall_last2", {63'd0, rd_last_a[2]}, 64'd0);
        check("stall_last3", {63'd0, rd_last_a[3]}, 64'd1);

        // FIXED burst repeats one word
        axi_read(32'h8000_0008, 8'd2, 2'b00, 1'b0);
        check("fixed_nbeats", 64'(nbeats), 64'd3);
        check("fixed_b0", rd_data_a[0], 64'hA5A5_0000_5A5A_0001);
        check("fixed_b1", rd_data_a[1], 64'hA5A5_0000_5A5A_0001);
        check("fixed_b2", rd_data_a[2], 64'hA5A5_0000_5A5A_0001);

        // Same-cycle read and write of word 5
        @(negedge clk);
        awaddr = 32'h8000_0028; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        araddr = 32'h8000_0028; arlen = 8'd0; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
        check("coll_both_ready", {63'd0, wready && arready}, 64'd1);
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        check("coll_rvalid", {63'd0, rvalid}, 64'd1);
        check("coll_old_data", rdata, 64'hA5A5_0000_5A5A_0005);
        check("coll_rlast", {63'd0, rlast}, 64'd1);
        check("coll_bvalid", {63'd0, bvalid}, 64'd1);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        check("coll_r_done", {63'd0, rvalid}, 64'd0);
        check("coll_b_done", {63'd0, bvalid}, 64'd0);
        $display("[TB] collision read+write word5");
        axi_read(32'h8000_0028, 8'd0, 2'b01, 1'b0);
        check("coll_new_data", rd_data_a[0], 64'hDEAD_BEEF_CAFE_F00D);

        // Address below the window
        wbuf_data[0] = 64'h0BAD_0BAD_0BAD_0BAD; wbuf_strb[0] = 8'hFF;
        axi_write(32'h7000_0000, 8'd0, 1, wr_resp);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        check("oor_bresp", {62'd0, wr_resp}, 64'd2);
        axi_read(32'h8000_0000, 8'd0, 2'b01, 1'b0);
        check("oor_w0_kept", rd_data_a[0], 64'hA5A5_0000_5A5A_0000);
        axi_read(32'h7000_0000, 8'd0, 2'b01, 1'b0);
        check("oor_rresp", {62'd0, rd_resp_a[0]}, 64'd2);
        check("oor_rdata", rd_data_a[0], 64'd0);
`else
        check("wrap_bresp", {62'd0, wr_resp}, 64'd0);
        axi_read(32'h8000_0000, 8'd0, 2'b01, 1'b0);
        check("wrap_w0", rd_data_a[0], 64'h0BAD_0BAD_0BAD_0BAD);
        axi_read(32'h7000_0000, 8'd0, 2'b01, 1'b0);
        check("wrap_rresp", {62'd0, rd_resp_a[0]}, 64'd0);
        check("wrap_rdata", rd_data_a[0], 64'h0BAD_0BAD_0BAD_0BAD);
`endif

        // Burst crossing the top of the array
        axi_read(32'h8000_7FF8, 8'd1, 2'b01, 1'b0);
        check("top_nbeats", 64'(nbeats), 64'd2);
        check("top_resp0", {62'd0, rd_resp_a[0]}, 64'd0);
`ifdef AXI_SLAVE_RANGE_CHECK_EN
        check("top_resp1", {62'd0, rd_resp_a[1]}, 64'd2);
        check("top_data1", rd_data_a[1], 64'd0);
`else
        check("top_resp1", {62'd0, rd_resp_a[1]}, 64'd0);
        check("top_data1", rd_data_a[1], 64'h0BAD_0BAD_0BAD_0BAD);
`endif

        // Reset during a read burst and a write burst
        @(negedge clk);
        araddr = 32'h8000_0000; arlen = 8'd7; arburst = 2'b01; arsize = 3'd3; arvalid = 1'b1;
        awaddr = 32'h8000_0050; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; rready = 1'b1;
        wdata = 64'h5555_5555_5555_5555; wstrb = 8'hFF; wvalid = 1'b1; wlast = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rvalid", {63'd0, rvalid}, 64'd0);
        check("abort_arready", {63'd0, arready}, 64'd1);
        check("abort_wready", {63'd0, wready}, 64'd0);
        check("abort_awready", {63'd0, awready}, 64'd1);
        @(negedge clk);
        check("abort_no_rbeat", {63'd0, rvalid}, 64'd0);
        check("abort_no_b", {63'd0, bvalid}, 64'd0);
        $display("[TB] reset mid-burst");
        axi_read(32'h8000_0010, 8'd0, 2'b01, 1'b0);
        check("mem_kept_w2", rd_data_a[0], 64'h1122_3344_5566_7788);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
